// File: rtl/key_conditioner_if.sv
// Key bundle between the board buttons and the draw/game-logic block.
// master drives the raw buttons; slave is the conditioner producing the clean keys.
interface key_conditioner_if;
    logic [3:0] key_in;
    logic [3:0] key_out;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       any_pressed;

    modport master (
        output key_in,
        input  key_out,
        input  press_pulse,
        input  release_pulse,
        input  any_pressed
    );

    modport slave (
        input  key_in,
        output key_out,
        output press_pulse,
        output release_pulse,
        output any_pressed
    );
endinterface

// File: rtl/key_conditioner.sv
// Synchronises and debounces the four raw push-buttons, applies per-key output
// polarity and emits one-cycle press/release pulses.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20,
    parameter logic [3:0]  INVERT_MASK     = 4'b1100
) (
    input logic               clock,
    input logic               resetn,
    key_conditioner_if.slave  keys
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       s1_q, s2_q;
    logic [3:0]       pr_q, pr_d;
    logic [3:0]       press_q, press_d;
    logic [3:0]       release_q, release_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       p;

    // Raw buttons are active-low; p is the synchronised "pressed" level.
    assign p = ~s2_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_q      <= '1;
            s2_q      <= '1;
            pr_q      <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            s1_q      <= keys.key_in;
            s2_q      <= s1_q;
            pr_q      <= pr_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        pr_d      = pr_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
        for (int i = 0; i < 4; i++) begin
            if (p[i] == pr_q[i]) begin
                // Any cycle back at the stable level restarts the qualification.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                pr_d[i]      = p[i];
                cnt_d[i]     = '0;
                press_d[i]   = p[i];
                release_d[i] = ~p[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Mask bit 1 passes pr through (active-high), 0 inverts it (active-low).
    assign keys.key_out       = pr_q ~^ INVERT_MASK;
    assign keys.press_pulse   = press_q;
    assign keys.release_pulse = release_q;
    assign keys.any_pressed   = |pr_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a short debounce window (4 cycles).
module tb_key_conditioner;

    logic clock;
    logic resetn;
    int   errors;
    int   checks;
    int   press_count;

    key_conditioner_if keys ();

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .INVERT_MASK    (4'b1100)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .keys  (keys.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past the next rising edge; outputs are sampled 1 ns after it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] ko, input logic [3:0] pp,
                             input logic [3:0] rp, input logic ap);
        check({tag, ".key_out"}, 32'(keys.key_out), 32'(ko));
        check({tag, ".press"}, 32'(keys.press_pulse), 32'(pp));
        check({tag, ".release"}, 32'(keys.release_pulse), 32'(rp));
        check({tag, ".any"}, 32'(keys.any_pressed), 32'(ap));
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        press_count = 0;
        resetn      = 1'b0;
        keys.key_in = 4'b0000;

        // Reset held with every button pressed: nothing may leak through.
        tick(3);
        check_all("reset", 4'b0011, 4'b0000, 4'b0000, 1'b0);

        resetn      = 1'b1;
        keys.key_in = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            check_all("idle", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        end

        // Clean press of key 3: visible at E+5.
        keys.key_in = 4'b0111;
        tick(5);
        check_all("k3_press_early", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        check_all("k3_press", 4'b1011, 4'b1000, 4'b0000, 1'b1);
        tick(1);
        check_all("k3_press_after", 4'b1011, 4'b0000, 4'b0000, 1'b1);

        keys.key_in = 4'b1111;
        tick(5);
        check_all("k3_rel_early", 4'b1011, 4'b0000, 4'b0000, 1'b1);
        tick(1);
        check_all("k3_rel", 4'b0011, 4'b0000, 4'b1000, 1'b0);
        tick(1);
        check_all("k3_rel_after", 4'b0011, 4'b0000, 4'b0000, 1'b0);

        // Bouncing key 0: low 3, high 1, low 3, high -- never qualifies.
        keys.key_in = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check_all("bounce_a", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        end
        keys.key_in = 4'b1111;
        tick(1);
        check_all("bounce_b", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        keys.key_in = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check_all("bounce_c", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        end
        keys.key_in = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check_all("bounce_d", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        end

        // Key 0 held long enough: active-low output drops.
        keys.key_in = 4'b1110;
        tick(5);
        check_all("k0_press_early", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        check_all("k0_press", 4'b0010, 4'b0001, 4'b0000, 1'b1);
        keys.key_in = 4'b1111;
        tick(6);
        check_all("k0_rel", 4'b0011, 4'b0000, 4'b0001, 1'b0);

        // Keys 3 and 2 together.
        keys.key_in = 4'b0011;
        tick(6);
        check_all("sim_press", 4'b1111, 4'b1100, 4'b0000, 1'b1);
        tick(1);
        check_all("sim_press_after", 4'b1111, 4'b0000, 4'b0000, 1'b1);
        keys.key_in = 4'b1111;
        tick(6);
        check_all("sim_rel", 4'b0011, 4'b0000, 4'b1100, 1'b0);

        // Reset mid-debounce: partial count must be discarded.
        keys.key_in = 4'b1011;
        tick(3);
        resetn = 1'b0;
        #1;
        check_all("rst_mid_now", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        resetn = 1'b1;
        tick(5);
        check_all("rst_mid_early", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        check_all("rst_mid_press", 4'b0111, 4'b0100, 4'b0000, 1'b1);

        // Reset while key 2 is stably pressed drops it asynchronously.
        tick(2);
        resetn = 1'b0;
        #1;
        check_all("rst_pressed_now", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        tick(1);
        resetn      = 1'b1;
        keys.key_in = 4'b1111;
        tick(8);
        check_all("rst_pressed_after", 4'b0011, 4'b0000, 4'b0000, 1'b0);

        // Long hold of key 3: a single press pulse, counter parked at 0.
        keys.key_in = 4'b0111;
        for (int k = 0; k < 1000; k++) begin
            tick(1);
            if (keys.press_pulse[3]) press_count++;
            check("long_no_release", 32'(keys.release_pulse), 32'd0);
        end
        check("long_press_count", 32'(press_count), 32'd1);
        check_all("long_end", 4'b1011, 4'b0000, 4'b0000, 1'b1);
        check("long_cnt_idle", 32'(dut.cnt_q[3]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
